// File: rtl/psum_drain_acc_pkg.sv
// Shared types and helpers for the psum drain accumulator.
// Holds the FSM state type, default widths and lane sign extension.
package psum_drain_acc_pkg;

    localparam int BW_DEF      = 11;
    localparam int PSUM_BW_DEF = 16;
    localparam int LEN_BW_DEF  = 5;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    // Sign-extend the low w bits of raw to 32 bits.
    function automatic logic [31:0] lane_sext(
        input logic [31:0] raw,
        input int unsigned w
    );
        logic [31:0] sh;
        sh = raw << (32 - w);
        return $signed(sh) >>> (32 - w);
    endfunction

endpackage

// File: rtl/psum_lane_acc.sv
// One lane's signed wrapping accumulator.
// The sum output is the value the accumulator would take on the next enable.
module psum_lane_acc
    import psum_drain_acc_pkg::*;
#(
    parameter int bw      = BW_DEF,
    parameter int psum_bw = PSUM_BW_DEF
) (
    input  logic               rd_clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               en,
    input  logic [bw-1:0]      lane,
    output logic [psum_bw-1:0] sum
);

    logic [psum_bw-1:0] acc;
    logic [psum_bw-1:0] ext;

    assign ext = psum_bw'(lane_sext(32'(lane), bw));
    assign sum = acc + ext;

    always_ff @(posedge rd_clk) begin
        if (reset || clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/psum_drain_acc.sv
// Drains SIMD partial-sum words from the output FIFO, sums acc_len words
// per lane and hands each result to the psum writer over valid/ready.
module psum_drain_acc
    import psum_drain_acc_pkg::*;
#(
    parameter int bw      = BW_DEF,
    parameter int simd    = 1,
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int len_bw  = LEN_BW_DEF
) (
    input  logic                    rd_clk,
    input  logic                    reset,
    input  logic [simd*bw-1:0]      fifo_out,
    input  logic                    fifo_empty,
    output logic                    fifo_rd,
    input  logic                    start,
    input  logic [len_bw-1:0]       acc_len,
    input  logic [len_bw-1:0]       num_out,
    output logic [simd*psum_bw-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam logic [len_bw-1:0] ONE = 1;

    state_t state;
    state_t state_nx;

    logic [len_bw-1:0] acc_len_q;
    logic [len_bw-1:0] num_out_q;
    logic [len_bw-1:0] word_cnt;
    logic [len_bw-1:0] res_cnt;

    logic consume;
    logic last_word;
    logic last_res;
    logic hshk;
    logic job_go;
    logic zero_go;
    logic clr;

    logic [simd*psum_bw-1:0] sum_all;

    assign consume   = (state == ACC) && !fifo_empty;
    assign last_word = consume && (word_cnt == acc_len_q - ONE);
    assign hshk      = (state == HOLD) && out_ready;
    assign last_res  = (res_cnt == num_out_q - ONE);
    assign job_go    = (state == IDLE) && start
                       && (acc_len != '0) && (num_out != '0);
    assign zero_go   = (state == IDLE) && start
                       && ((acc_len == '0) || (num_out == '0));
    assign clr       = job_go || hshk;

    assign fifo_rd   = consume;
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (job_go) state_nx = ACC;
            ACC:  if (last_word) state_nx = HOLD;
            HOLD: if (hshk) state_nx = last_res ? IDLE : ACC;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            acc_len_q <= '0;
            num_out_q <= '0;
            word_cnt  <= '0;
            res_cnt   <= '0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= zero_go || (hshk && last_res);
            if (job_go) begin
                acc_len_q <= acc_len;
                num_out_q <= num_out;
                word_cnt  <= '0;
                res_cnt   <= '0;
            end else if (hshk) begin
                word_cnt <= '0;
                res_cnt  <= res_cnt + ONE;
            end else if (consume) begin
                word_cnt <= word_cnt + ONE;
            end
            // Capture includes the word consumed on this same edge.
            if (last_word) begin
                out_data <= sum_all;
            end
        end
    end

    for (genvar i = 0; i < simd; i++) begin : g_lane
        psum_lane_acc #(
            .bw      (bw),
            .psum_bw (psum_bw)
        ) u_lane (
            .rd_clk (rd_clk),
            .reset  (reset),
            .clear  (clr),
            .en     (consume),
            .lane   (fifo_out[i*bw +: bw]),
            .sum    (sum_all[i*psum_bw +: psum_bw])
        );
    end

endmodule

// File: tb/tb_psum_drain_acc.sv
// Directed bench for psum_drain_acc: a 2-lane 16-bit instance with a
// modelled FIFO, plus a 1-lane 11-bit instance for accumulator wrap.
module tb_psum_drain_acc;

    localparam int BW   = 11;
    localparam int SIMD = 2;
    localparam int PBW  = 16;
    localparam int LBW  = 5;

    logic                 rd_clk = 1'b0;
    logic                 reset  = 1'b1;
    logic [SIMD*BW-1:0]   fifo_out;
    logic                 fifo_empty;
    logic                 fifo_rd;
    logic                 start = 1'b0;
    logic [LBW-1:0]       acc_len = '0;
    logic [LBW-1:0]       num_out = '0;
    logic [SIMD*PBW-1:0]  out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic                 busy;
    logic                 done;

    logic [BW-1:0]        fifo_out_b = 11'd1023;
    logic                 fifo_empty_b = 1'b0;
    logic                 fifo_rd_b;
    logic                 start_b = 1'b0;
    logic [LBW-1:0]       acc_len_b = '0;
    logic [LBW-1:0]       num_out_b = '0;
    logic [BW-1:0]        out_data_b;
    logic                 out_valid_b;
    logic                 out_ready_b = 1'b1;
    logic                 busy_b;
    logic                 done_b;

    logic [SIMD*BW-1:0]   mem [0:15];
    int                   wr_ptr = 0;
    int                   rd_ptr = 0;
    logic                 stall = 1'b0;
    logic                 stall_en = 1'b0;
    int                   viol = 0;

    int vectors = 0;
    int miscompares = 0;
    int n;

    always #5 rd_clk = ~rd_clk;

    assign fifo_out   = mem[rd_ptr & 15];
    assign fifo_empty = (rd_ptr == wr_ptr) || stall;

    always @(posedge rd_clk) begin
        if (fifo_rd) rd_ptr <= rd_ptr + 1;
        if (fifo_rd && fifo_empty) viol <= viol + 1;
    end

    always @(negedge rd_clk) begin
        stall <= stall_en ? ~stall : 1'b0;
    end

    psum_drain_acc #(
        .bw(BW), .simd(SIMD), .psum_bw(PBW), .len_bw(LBW)
    ) dut (
        .rd_clk     (rd_clk),
        .reset      (reset),
        .fifo_out   (fifo_out),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .start      (start),
        .acc_len    (acc_len),
        .num_out    (num_out),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    psum_drain_acc #(
        .bw(BW), .simd(1), .psum_bw(BW), .len_bw(LBW)
    ) dut_wrap (
        .rd_clk     (rd_clk),
        .reset      (reset),
        .fifo_out   (fifo_out_b),
        .fifo_empty (fifo_empty_b),
        .fifo_rd    (fifo_rd_b),
        .start      (start_b),
        .acc_len    (acc_len_b),
        .num_out    (num_out_b),
        .out_data   (out_data_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic push(input int l1, input int l0);
        logic [31:0] a;
        logic [31:0] b;
        a = l1;
        b = l0;
        mem[wr_ptr & 15] = {a[BW-1:0], b[BW-1:0]};
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    // Call after settle(); returns with out_valid high or reports a timeout.
    task automatic wait_valid(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (out_valid) break;
            tick();
            settle();
        end
        chk(tag, out_valid, 1);
    endtask

    initial begin
        repeat (3) tick();
        settle();
        chk("rst_valid", out_valid, 0);
        chk("rst_rd", fifo_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_valid_b", out_valid_b, 0);
        tick();
        reset = 1'b0;

        // basic sum
        push(-1, 1); push(-2, 2); push(-3, 3); push(-4, 4);
        start = 1'b1; acc_len = 4; num_out = 1;
        tick();
        start = 1'b0;
        settle();
        chk("t1_busy_c1", busy, 1);
        chk("t1_rd_c1", fifo_rd, 1);
        repeat (4) tick();
        settle();
        chk("t1_valid_c5", out_valid, 1);
        chk("t1_data", out_data, 32'hFFF6_000A);
        chk("t1_rd_hold", fifo_rd, 0);
        tick();
        settle();
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_valid_end", out_valid, 0);
        tick();
        settle();
        chk("t1_done_once", done, 0);

        // empty stall
        push(-1, 1); push(-2, 2); push(-3, 3); push(-4, 4);
        stall_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        settle();
        wait_valid("t2_valid");
        chk("t2_data", out_data, 32'hFFF6_000A);
        chk("t2_no_rd_empty", viol, 0);
        stall_en = 1'b0;
        tick();
        settle();
        chk("t2_done", done, 1);

        // back-pressure
        out_ready = 1'b0;
        push(100, 5); push(-50, 6); push(0, 7); push(9, 9);
        start = 1'b1; acc_len = 3; num_out = 1;
        tick();
        start = 1'b0;
        settle();
        wait_valid("t3_valid");
        chk("t3_data", out_data, 32'h0032_0012);
        for (int i = 0; i < 7; i++) begin
            tick();
            settle();
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_data", out_data, 32'h0032_0012);
            chk("t3_hold_rd", fifo_rd, 0);
        end
        out_ready = 1'b1;
        tick();
        settle();
        chk("t3_done", done, 1);
        chk("t3_valid_drop", out_valid, 0);
        chk("t3_idle_rd", fifo_rd, 0);
        flush();

        // multi-result and wrap
        for (int i = 0; i < 6; i++) push(1023, 1023);
        start = 1'b1; acc_len = 2; num_out = 3;
        start_b = 1'b1; acc_len_b = 2; num_out_b = 1;
        tick();
        start = 1'b0;
        start_b = 1'b0;
        tick();
        tick();
        settle();
        chk("t4_valid_b", out_valid_b, 1);
        chk("t4_wrap_b", out_data_b, 11'h7FE);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                chk("t4_data", out_data, 32'h07FE_07FE);
                n++;
            end
            if (done) break;
            tick();
            settle();
        end
        chk("t4_count", n, 3);
        chk("t4_done", done, 1);
        chk("t4_done_b", busy_b, 0);

        // zero length
        push(1, 1);
        start = 1'b1; acc_len = 0; num_out = 3;
        settle();
        chk("t5_busy_pre", busy, 0);
        tick();
        start = 1'b0;
        settle();
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 0);
        chk("t5_rd", fifo_rd, 0);
        tick();
        settle();
        chk("t5_done_once", done, 0);
        chk("t5_rd_after", fifo_rd, 0);
        flush();

        // reset mid-job
        push(1, 10); push(1, 20); push(1, 30); push(1, 40);
        start = 1'b1; acc_len = 4; num_out = 1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        settle();
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_rd", fifo_rd, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_data", out_data, 0);
        reset = 1'b0;
        flush();
        push(2, 1); push(2, 1); push(2, 1); push(2, 1);
        start = 1'b1; acc_len = 4; num_out = 1;
        tick();
        start = 1'b0;
        settle();
        wait_valid("t6_valid");
        chk("t6_data", out_data, 32'h0008_0004);
        tick();
        settle();
        chk("t6_done", done, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
